axi4_lite_slave_regs: RTL and testbench
=======================================

// Module: axi4_lite_slave_regs
// PURPOSE
//  AXI4-Lite responder: terminates all five channels from the AXI4-Lite master and maps them onto a bank of
//  NUM_REGS 32-bit registers. Write path and read path run in parallel. Contents drive fabric through reg_flat;
//  each committed write raises a one-cycle pulse.
// PARAMETERS
//  ADDR_W    32            address width of awaddr/araddr
//  NUM_REGS  8             register count (power of 2, 2..256)
//  RO_MASK   {NUM_REGS{0}} bit i=1: register i is read-only (writes rejected with SLVERR)
//  RESET_VAL 32'h0         reset value of every register
// PORTS
//  aclk      in   1            clock, all logic on rising edge
//  areset    in   1            asynchronous reset, active-high
//  awaddr    in   ADDR_W       write address
//  awprot    in   3            write protection (accepted, ignored)
//  awvalid   in   1 / awready out 1   write address handshake
//  wdata     in   32           write data
//  wstrb     in   4            byte strobes, bit i -> wdata[8i+7:8i]
//  wvalid    in   1 / wready out 1    write data handshake
//  bresp     out  2            write response, 00 OKAY / 10 SLVERR
//  bvalid    out  1 / bready in 1     write response handshake
//  araddr    in   ADDR_W       read address
//  arprot    in   3            read protection (accepted, ignored)
//  arvalid   in   1 / arready out 1   read address handshake
//  rdata     out  32           read data
//  rresp     out  2            read response, 00 OKAY / 10 SLVERR
//  rvalid    out  1 / rready in 1     read data handshake
//  reg_flat  out  32*NUM_REGS  register contents, reg i at [32i+31:32i]
//  wr_pulse  out  1            one-cycle pulse on each committed (OKAY) write
//  wr_idx    out  log2(NUM_REGS) index of the written register, valid with wr_pulse
// BEHAVIOUR
//  Reset (async): FSMs -> IDLE; all registers = RESET_VAL; bvalid = rvalid = wr_pulse = 0; bresp = rresp = 00;
//   rdata = 0; all readies forced 0 while areset is high. Mid-transaction reset drops pending transfers silently.
//  Decode: idx = addr[2 +: log2(NUM_REGS)], addr[1:0] ignored. Out of range: addr >= 4*NUM_REGS -> SLVERR.
//  Write FSM: WR_IDLE, WR_WAIT_DATA, WR_WAIT_ADDR, WR_RESP. Readies decode from state only (never from valids):
//   awready=1 in IDLE and WAIT_ADDR; wready=1 in IDLE and WAIT_DATA; both 0 in RESP.
//   IDLE: AW+W same cycle -> commit at that edge, RESP. AW only -> latch addr, WAIT_DATA.
//    W only -> latch data and strobe, WAIT_ADDR.
//   WAIT_*: missing handshake -> commit with latched half, RESP.
//   Commit: in range and not RO -> byte i updated iff wstrb[i]; bresp=00; wr_pulse=1 for the next cycle only.
//    Otherwise no register changes; bresp=10; no pulse. wstrb=0 in range -> OKAY, no change, pulse still fires.
//   RESP: bvalid=1 and bresp stable until bready; bvalid&bready -> IDLE (bvalid low the following cycle).
//   Write latency: both handshakes -> bvalid one cycle later. Max one outstanding write.
//  Read FSM: RD_IDLE, RD_DATA. arready=1 only in RD_IDLE.
//   arvalid&arready -> rdata/rresp registered at that edge, RD_DATA. Out of range: rdata=0, rresp=10.
//   RD_DATA: rvalid=1; rdata/rresp stable until rready; rvalid&rready -> RD_IDLE. Read latency 1 cycle.
//  Simultaneous: a read captured at the same edge as a write commit to that register returns the OLD value.
//  Read and write channels never stall each other.
// STRUCTURE
//  axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; write/read FSM state localparams.
//  Sub-module axi4_lite_reg_bank: NUM_REGS x 32 storage. Byte-strobe write port (we, idx, data, strb).
//   Combinational read port. Flat output. Async reset to RESET_VAL.
//  Top holds both FSMs, address/data latches, decode, response generation.
// TESTING (NUM_REGS=8, RO_MASK=8'h80, RESET_VAL=0)
//  1 AW+W same cycle: awaddr=16, wdata=F0B4A596, wstrb=1011 -> bvalid next cycle, bresp=00.
//    reg4=F000A596; wr_pulse=1, wr_idx=4 for one cycle.
//  2 AW leads W by 3 cycles, then W leads AW by 3 cycles.
//    -> awready/wready drop after own handshake; data written correctly; one bresp each.
//  3 araddr=32 -> rresp=10, rdata=0. araddr=16 after test 1 -> rdata=F000A596, rresp=00.
//  4 Write awaddr=28 (reg7 RO) -> bresp=10, reg7 stays 0, no wr_pulse.
//    bready held low 5 cycles -> bvalid/bresp held, awready=0.
//  5 Read reg4 captured at the commit edge of a write of 12345678 to reg4 -> rdata is the old value.
//    A subsequent read returns 12345678.
//  6 areset pulsed while in WR_WAIT_DATA and RD_DATA -> bvalid=rvalid=0 immediately; regs=0; FSMs IDLE.
//    A new write completes normally after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register slave: response codes, FSM state
// encodings and the byte-strobe merge helper used by the register bank.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE      = 2'd0,
    WR_WAIT_DATA = 2'd1,
    WR_WAIT_ADDR = 2'd2,
    WR_RESP      = 2'd3
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// NUM_REGS x 32-bit register storage with one byte-strobed write port,
// a combinational read port and a flat view of all contents.
module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] RESET_VAL = 32'h0,
  localparam int         IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [31:0]              wr_data,
  input  logic [3:0]               wr_strb,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [31:0]              rd_data,
  output logic [32*NUM_REGS-1:0]   reg_flat
);

  logic [31:0] regs_r [NUM_REGS];

  // Register storage: async reset to RESET_VAL, byte-strobed update on we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else if (we) begin
      regs_r[wr_idx] <= strb_merge(regs_r[wr_idx], wr_data, wr_strb);
    end
  end

  // Pre-edge contents, so a read captured at a commit edge returns the old value.
  assign rd_data = regs_r[rd_idx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[32*g +: 32] = regs_r[g];
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating all five channels onto a register bank; independent
// write and read FSMs, SLVERR for out-of-range or read-only targets.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int                  ADDR_W    = 32,
  parameter int                  NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK   = {NUM_REGS{1'b0}},
  parameter logic [31:0]         RESET_VAL = 32'h0,
  localparam int                 IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [ADDR_W-1:0]      awaddr,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [ADDR_W-1:0]      araddr,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [32*NUM_REGS-1:0] reg_flat,
  output logic                   wr_pulse,
  output logic [IDX_W-1:0]       wr_idx
);

  wr_state_t         wr_state_r;
  rd_state_t         rd_state_r;
  logic [ADDR_W-1:0] aw_addr_r;
  logic [31:0]       w_data_r;
  logic [3:0]        w_strb_r;

  logic              aw_hs_s;
  logic              w_hs_s;
  logic              commit_s;
  logic [ADDR_W-1:0] commit_addr_s;
  logic [31:0]       commit_data_s;
  logic [3:0]        commit_strb_s;
  logic [IDX_W-1:0]  commit_idx_s;
  logic              wr_in_range_s;
  logic              wr_ok_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              rd_in_range_s;
  logic [31:0]       bank_rd_data_s;
  logic              unused_s;

  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid & wready;

  // Select the address/data halves that complete a write this cycle.
  always_comb begin
    commit_s      = 1'b0;
    commit_addr_s = awaddr;
    commit_data_s = wdata;
    commit_strb_s = wstrb;
    case (wr_state_r)
      WR_IDLE:      commit_s = aw_hs_s & w_hs_s;
      WR_WAIT_DATA: begin
        commit_s      = w_hs_s;
        commit_addr_s = aw_addr_r;
      end
      WR_WAIT_ADDR: begin
        commit_s      = aw_hs_s;
        commit_data_s = w_data_r;
        commit_strb_s = w_strb_r;
      end
      default:      commit_s = 1'b0;
    endcase
  end

  assign commit_idx_s  = commit_addr_s[2 +: IDX_W];
  assign wr_in_range_s = (commit_addr_s >> (2 + IDX_W)) == {ADDR_W{1'b0}};
  assign wr_ok_s       = commit_s & wr_in_range_s & ~RO_MASK[commit_idx_s];
  assign rd_idx_s      = araddr[2 +: IDX_W];
  assign rd_in_range_s = (araddr >> (2 + IDX_W)) == {ADDR_W{1'b0}};
  assign unused_s      = ^{awprot, arprot, awaddr[1:0], araddr[1:0], aw_addr_r[1:0]};

  axi4_lite_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk      (aclk),
    .rst      (areset),
    .we       (wr_ok_s),
    .wr_idx   (commit_idx_s),
    .wr_data  (commit_data_s),
    .wr_strb  (commit_strb_s),
    .rd_idx   (rd_idx_s),
    .rd_data  (bank_rd_data_s),
    .reg_flat (reg_flat)
  );

  // Write FSM; readies are registered from the next state so they stay low in reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state_r <= WR_IDLE;
      awready    <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      wr_pulse   <= 1'b0;
      wr_idx     <= {IDX_W{1'b0}};
      aw_addr_r  <= {ADDR_W{1'b0}};
      w_data_r   <= 32'h0;
      w_strb_r   <= 4'h0;
    end else begin
      wr_pulse <= wr_ok_s;
      if (wr_ok_s) begin
        wr_idx <= commit_idx_s;
      end
      if (commit_s) begin
        wr_state_r <= WR_RESP;
        awready    <= 1'b0;
        wready     <= 1'b0;
        bvalid     <= 1'b1;
        bresp      <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
        case (wr_state_r)
          WR_IDLE: begin
            if (aw_hs_s) begin
              aw_addr_r  <= awaddr;
              wr_state_r <= WR_WAIT_DATA;
              awready    <= 1'b0;
              wready     <= 1'b1;
            end else if (w_hs_s) begin
              w_data_r   <= wdata;
              w_strb_r   <= wstrb;
              wr_state_r <= WR_WAIT_ADDR;
              awready    <= 1'b1;
              wready     <= 1'b0;
            end else begin
              awready <= 1'b1;
              wready  <= 1'b1;
            end
          end
          WR_WAIT_DATA: begin
            awready <= 1'b0;
            wready  <= 1'b1;
          end
          WR_WAIT_ADDR: begin
            awready <= 1'b1;
            wready  <= 1'b0;
          end
          WR_RESP: begin
            if (bvalid & bready) begin
              wr_state_r <= WR_IDLE;
              bvalid     <= 1'b0;
              awready    <= 1'b1;
              wready     <= 1'b1;
            end
          end
          default: begin
            wr_state_r <= WR_IDLE;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read FSM: data and response registered at the AR handshake edge.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state_r <= RD_IDLE;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= 32'h0;
      rresp      <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (arvalid & arready) begin
            rdata      <= rd_in_range_s ? bank_rd_data_s : 32'h0;
            rresp      <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
            rvalid     <= 1'b1;
            arready    <= 1'b0;
            rd_state_r <= RD_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rready) begin
            rvalid     <= 1'b0;
            arready    <= 1'b1;
            rd_state_r <= RD_IDLE;
          end
        end
        default: begin
          rd_state_r <= RD_IDLE;
          arready    <= 1'b0;
          rvalid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench: table of read/write vectors plus hand-written corner sequences,
// with response/read-data/pulse scoreboards compared as the DUT produces output.
module tb_axi4_lite_slave_regs;

  logic         clk = 1'b0;
  logic         areset;
  logic [31:0]  awaddr, wdata, araddr, rdata;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, wr_pulse;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] reg_flat;
  logic [2:0]   wr_idx;

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [2:0]  pq [$];
  logic [31:0] mdl [8];
  logic [33:0] r_exp;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [12];

  axi4_lite_slave_regs #(
    .ADDR_W(32), .NUM_REGS(8), .RO_MASK(8'h80), .RESET_VAL(32'h0)
  ) dut (
    .aclk(clk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_flat(reg_flat), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  // Scoreboard: compare responses, read data and write pulses as they appear.
  always @(negedge clk) begin
    if (!areset) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("bvalid_unexpected", 64'(bvalid), 64'd0);
        else chk("bresp", 64'(bresp), 64'(bq.pop_front()));
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("rvalid_unexpected", 64'(rvalid), 64'd0);
        else begin
          r_exp = rq.pop_front();
          chk("rdata_rresp", 64'({rdata, rresp}), 64'(r_exp));
        end
      end
      if (wr_pulse) begin
        if (pq.size() == 0) chk("wr_pulse_unexpected", 64'(wr_pulse), 64'd0);
        else chk("wr_idx", 64'(wr_idx), 64'(pq.pop_front()));
      end
    end
  end

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!awready && n < 50);
    if (!awready) chk("awready_timeout", 64'(awready), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!wready && n < 50);
    if (!wready) chk("wready_timeout", 64'(wready), 64'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    if (!arready) chk("arready_timeout", 64'(arready), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ad, input int wd, input logic [1:0] er);
    bq.push_back(er);
    if (er == 2'b00) begin
      pq.push_back(a[4:2]);
      mdl[a[4:2]] = merge(mdl[a[4:2]], d, s);
    end
    fork
      begin if (ad > 0) begin repeat (ad) @(posedge clk); #1; end send_aw(a); end
      begin if (wd > 0) begin repeat (wd) @(posedge clk); #1; end send_w(d, s); end
    join
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    rq.push_back({ed, er});
    send_ar(a);
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin @(posedge clk); n++; end
    chk("drain_pending", 64'(bq.size() + rq.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'd32, 32'h0,        4'h0,    0, 0, 2'b10, 32'h0};
    vecs[1]  = '{1'b1, 32'd16, 32'h0,        4'h0,    0, 0, 2'b00, 32'hF000A596};
    vecs[2]  = '{1'b1, 32'd0,  32'h0,        4'h0,    0, 0, 2'b00, 32'h11223344};
    vecs[3]  = '{1'b1, 32'd8,  32'h0,        4'h0,    0, 0, 2'b00, 32'h00007788};
    vecs[4]  = '{1'b0, 32'd4,  32'hAABBCCDD, 4'b0000, 0, 0, 2'b00, 32'h0};
    vecs[5]  = '{1'b1, 32'd4,  32'h0,        4'h0,    0, 0, 2'b00, 32'h0};
    vecs[6]  = '{1'b0, 32'd12, 32'hDEADBEEF, 4'b1100, 2, 0, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 32'd13, 32'h0,        4'h0,    0, 0, 2'b00, 32'hDEAD0000};
    vecs[8]  = '{1'b0, 32'd64, 32'h00000001, 4'b1111, 0, 2, 2'b10, 32'h0};
    vecs[9]  = '{1'b0, 32'd6,  32'hCAFEF00D, 4'b0001, 0, 1, 2'b00, 32'h0};
    vecs[10] = '{1'b1, 32'd4,  32'h0,        4'h0,    0, 0, 2'b00, 32'h0000000D};
    vecs[11] = '{1'b1, 32'd28, 32'h0,        4'h0,    0, 0, 2'b00, 32'h0};
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;

    areset = 1'b1; awaddr = 32'h0; awprot = 3'h0; awvalid = 1'b0; wdata = 32'h0;
    wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1; araddr = 32'h0; arprot = 3'h0;
    arvalid = 1'b0; rready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_valids_pulse", 64'({bvalid, rvalid, wr_pulse}), 64'd0);
    chk("rst_resps_rdata", 64'({bresp, rresp, rdata}), 64'd0);
    for (int i = 0; i < 8; i++) chk("rst_reg", 64'(reg_flat[32*i +: 32]), 64'd0);
    areset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // AW and W in the same cycle
    do_write(32'd16, 32'hF0B4A596, 4'b1011, 0, 0, 2'b00);
    @(negedge clk);
    chk("t1_bvalid", 64'(bvalid), 64'd1);
    chk("t1_pulse_idx", 64'({wr_pulse, wr_idx}), 64'({1'b1, 3'd4}));
    @(negedge clk);
    chk("t1_pulse_once", 64'({wr_pulse, bvalid}), 64'd0);
    chk("t1_reg4", 64'(reg_flat[128 +: 32]), 64'(32'hF000A596));
    @(posedge clk); #1;

    // AW leads W by three cycles
    bq.push_back(2'b00); pq.push_back(3'd0); mdl[0] = 32'h11223344;
    send_aw(32'd0);
    @(negedge clk);
    chk("t2a_readies", 64'({awready, wready}), 64'(2'b01));
    repeat (3) @(posedge clk); #1;
    send_w(32'h11223344, 4'b1111);
    drain();

    // W leads AW by three cycles
    bq.push_back(2'b00); pq.push_back(3'd2); mdl[2] = 32'h00007788;
    send_w(32'h55667788, 4'b0011);
    @(negedge clk);
    chk("t2b_readies", 64'({awready, wready}), 64'(2'b10));
    repeat (3) @(posedge clk); #1;
    send_aw(32'd8);
    drain();
    chk("t2_reg0", 64'(reg_flat[0 +: 32]), 64'(32'h11223344));
    chk("t2_reg2", 64'(reg_flat[64 +: 32]), 64'(32'h00007788));

    // Vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rd) do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
      else do_write(vecs[i].addr, vecs[i].data, vecs[i].strb,
                    vecs[i].aw_dly, vecs[i].w_dly, vecs[i].exp_resp);
      drain();
    end

    // Read-only register with bready held low
    bready = 1'b0;
    do_write(32'd28, 32'hFFFFFFFF, 4'b1111, 0, 0, 2'b10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_bvalid_held", 64'(bvalid), 64'd1);
      chk("t4_bresp_held", 64'(bresp), 64'(2'b10));
      chk("t4_awready_low", 64'(awready), 64'd0);
    end
    bready = 1'b1;
    drain();
    chk("t4_reg7", 64'(reg_flat[224 +: 32]), 64'd0);

    // Read captured at the same edge as a write commit to the same register
    rq.push_back({32'hF000A596, 2'b00});
    bq.push_back(2'b00); pq.push_back(3'd4); mdl[4] = 32'h12345678;
    fork
      send_aw(32'd16);
      send_w(32'h12345678, 4'b1111);
      send_ar(32'd16);
    join
    drain();
    do_read(32'd16, 32'h12345678, 2'b00);
    drain();

    // Reset during WR_WAIT_DATA and RD_DATA
    rready = 1'b0;
    send_ar(32'd0);
    send_aw(32'd20);
    @(negedge clk);
    chk("t6_pre_rvalid", 64'(rvalid), 64'd1);
    chk("t6_pre_readies", 64'({awready, wready}), 64'(2'b01));
    #2 areset = 1'b1;
    #1;
    chk("t6_valids", 64'({bvalid, rvalid}), 64'd0);
    chk("t6_readies", 64'({awready, wready, arready}), 64'd0);
    for (int i = 0; i < 8; i++) mdl[i] = 32'h0;
    for (int i = 0; i < 8; i++) chk("t6_reg", 64'(reg_flat[32*i +: 32]), 64'd0);
    awvalid = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    repeat (2) @(posedge clk); #1;
    do_write(32'd20, 32'h0BADF00D, 4'b1111, 0, 0, 2'b00);
    drain();
    do_read(32'd20, 32'h0BADF00D, 2'b00);
    drain();
    do_read(32'd16, 32'h0, 2'b00);
    drain();

    // Final register image and scoreboard state
    for (int i = 0; i < 8; i++) chk("final_reg", 64'(reg_flat[32*i +: 32]), 64'(mdl[i]));
    chk("pulses_outstanding", 64'(pq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
